// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, ALU_1bit operation encodings and sequencer states for the
// bit-serial ALU controller.
package alu_ctrl_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam logic [1:0] OPR_AND  = 2'b00;
   localparam logic [1:0] OPR_OR   = 2'b01;
   localparam logic [1:0] OPR_ADD  = 2'b10;
   localparam logic [1:0] OPR_LESS = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SLT2 = 2'd2,
      FIN  = 2'd3
   } state_t;

   function automatic logic op_supported(input logic [3:0] op);
      logic ok;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: ok = 1'b1;
         default:                                       ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Subtract-style ops start the carry chain at 1 (two's-complement +1).
   function automatic logic op_cin0(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_serial_ctrl_alu_1bit.sv
// One slice of the MIPS-style ripple ALU: optional operand inversion, full adder
// and a 4-way result select (and / or / sum / less).
module ALU_1bit
   import alu_ctrl_pkg::*;
(
   input  logic       src1,
   input  logic       src2,
   input  logic       less,
   input  logic       A_invert,
   input  logic       B_invert,
   input  logic       cin,
   input  logic [1:0] operation,
   output logic       result,
   output logic       cout
);

   logic w_a;
   logic w_b;
   logic w_sum;

   assign w_a   = src1 ^ A_invert;
   assign w_b   = src2 ^ B_invert;
   assign w_sum = w_a ^ w_b ^ cin;
   assign cout  = (w_a & w_b) | (w_a & cin) | (w_b & cin);

   // Result select by operation code.
   always_comb begin
      result = 1'b0;
      case (operation)
         OPR_AND:  result = w_a & w_b;
         OPR_OR:   result = w_a | w_b;
         OPR_ADD:  result = w_sum;
         OPR_LESS: result = less;
         default:  result = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: runs one WIDTH-bit operation through a single ALU_1bit,
// LSB first, with the carry chained through a register. SLT takes two passes.
module alu_serial_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       ALU_control,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow,
   output logic             err
);

   localparam int             IW   = $clog2(WIDTH);
   localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

   state_t            r_state;
   state_t            w_state_nx;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [3:0]        r_op;
   logic              r_bad;
   logic [IW-1:0]     r_idx;
   logic              r_carry;
   logic              r_set;
   logic [WIDTH-1:0]  r_result;
   logic              r_ready;
   logic              r_done;
   logic              r_zero;
   logic              r_cout;
   logic              r_ovf;
   logic              r_err;

   logic              w_ainv;
   logic              w_binv;
   logic              w_less;
   logic [1:0]        w_opr;
   logic              w_sum;
   logic              w_cout;
   logic              w_last;
   logic              w_arith;
   logic [WIDTH-1:0]  w_result_nx;

   assign w_last  = (r_idx == LAST);
   assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

   ALU_1bit u_alu (
      .src1      (r_a[r_idx]),
      .src2      (r_b[r_idx]),
      .less      (w_less),
      .A_invert  (w_ainv),
      .B_invert  (w_binv),
      .cin       (r_carry),
      .operation (w_opr),
      .result    (w_sum),
      .cout      (w_cout)
   );

   // Per-bit slice control from the latched opcode and the current pass.
   always_comb begin
      w_ainv = 1'b0;
      w_binv = 1'b0;
      w_less = 1'b0;
      w_opr  = OPR_AND;
      case (r_state)
         RUN: begin
            case (r_op)
               OP_AND: w_opr = OPR_AND;
               OP_OR:  w_opr = OPR_OR;
               OP_ADD: w_opr = OPR_ADD;
               OP_SUB, OP_SLT: begin
                  w_binv = 1'b1;
                  w_opr  = OPR_ADD;
               end
               OP_NOR: begin
                  w_ainv = 1'b1;
                  w_binv = 1'b1;
                  w_opr  = OPR_AND;
               end
               default: w_opr = OPR_AND;
            endcase
         end
         SLT2: begin
            w_binv = 1'b1;
            w_opr  = OPR_LESS;
            w_less = (r_idx == '0) ? r_set : 1'b0;
         end
         default: w_opr = OPR_AND;
      endcase
   end

   // Result with the current bit merged in.
   always_comb begin
      w_result_nx        = r_result;
      w_result_nx[r_idx] = w_sum;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nx = op_supported(ALU_control) ? RUN : FIN;
            end else begin
               w_state_nx = IDLE;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_nx = (r_op == OP_SLT) ? SLT2 : FIN;
            end else begin
               w_state_nx = RUN;
            end
         end
         SLT2: begin
            if (w_last) begin
               w_state_nx = FIN;
            end else begin
               w_state_nx = SLT2;
            end
         end
         FIN:     w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // Operand latch, bit sequencing and output flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= 4'b0000;
         r_bad    <= 1'b0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_set    <= 1'b0;
         r_result <= '0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_zero   <= 1'b1;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a      <= src1;
                  r_b      <= src2;
                  r_op     <= ALU_control;
                  r_bad    <= ~op_supported(ALU_control);
                  r_idx    <= '0;
                  r_carry  <= op_cin0(ALU_control);
                  r_result <= '0;
                  r_ready  <= 1'b0;
                  r_zero   <= 1'b1;
                  r_cout   <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_err    <= 1'b0;
               end
            end
            RUN: begin
               r_idx   <= r_idx + 1'b1;
               r_carry <= w_cout;
               if (r_op != OP_SLT) begin
                  r_result <= w_result_nx;
               end
               if (w_last) begin
                  r_idx <= '0;
                  if (r_op == OP_SLT) begin
                     // Sign of the difference, corrected for signed overflow.
                     r_set   <= w_sum ^ r_carry ^ w_cout;
                     r_carry <= 1'b1;
                  end else begin
                     r_zero <= (w_result_nx == '0);
                     if (w_arith) begin
                        r_cout <= w_cout;
                        r_ovf  <= r_carry ^ w_cout;
                     end
                  end
               end
            end
            SLT2: begin
               r_idx    <= r_idx + 1'b1;
               r_carry  <= w_cout;
               r_result <= w_result_nx;
               if (w_last) begin
                  r_idx  <= '0;
                  r_zero <= (w_result_nx == '0);
               end
            end
            FIN: begin
               r_done  <= 1'b1;
               r_ready <= 1'b1;
               r_err   <= r_bad;
            end
            default: r_done <= 1'b0;
         endcase
      end
   end

   assign ready    = r_ready;
   assign done     = r_done;
   assign result   = r_result;
   assign zero     = r_zero;
   assign cout     = r_cout;
   assign overflow = r_ovf;
   assign err      = r_err;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl at WIDTH=32 with hand-computed expectations,
// including latency, ignored mid-run start and reset abort.
module tb_alu_serial_ctrl;
   import alu_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [3:0]  ALU_control;
   logic        ready;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        cout;
   logic        overflow;
   logic        err;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int pulses;

   alu_serial_ctrl #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .src1        (src1),
      .src2        (src2),
      .ALU_control (ALU_control),
      .ready       (ready),
      .done        (done),
      .result      (result),
      .zero        (zero),
      .cout        (cout),
      .overflow    (overflow),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one op; cyc = edges from accept until done is seen (-1 on timeout).
   // A stray start with other operands is pulsed after edge glitch_at (if > 0).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_at, output int cyc_o);
      int guard;
      guard = 0;
      while (!ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      ALU_control = op;
      src1        = a;
      src2        = b;
      start       = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
      src1        = ~a;
      src2        = ~b;
      ALU_control = 4'b1111;
      cyc_o       = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (k == glitch_at) begin
            check_val("busy_ready", {31'b0, ready}, 32'd0);
            start       = 1'b1;
            src1        = 32'hDEAD_BEEF;
            src2        = 32'h0000_0001;
            ALU_control = OP_SUB;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            cyc_o = k;
            break;
         end
      end
      start = 1'b0;
      if (cyc_o < 0) begin
         check_val("timeout", {31'b0, done}, 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; ALU_control = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", {31'b0, ready}, 32'd1);
      check_val("rst_done", {31'b0, done}, 32'd0);
      check_val("rst_result", result, 32'h0);
      check_val("rst_zero", {31'b0, zero}, 32'd1);
      check_val("rst_flags", {28'b0, cout, overflow, err, 1'b0}, 32'd0);
      rst = 1'b0;

      run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, cyc);
      check_val("add_lat", cyc, 32'd33);
      check_val("add_res", result, 32'h8000_0000);
      check_val("add_flags", {28'b0, zero, cout, overflow, err}, 32'b0010);
      check_val("add_ready", {31'b0, ready}, 32'd1);
      @(posedge clk); #1;
      check_val("done_pulse", {31'b0, done}, 32'd0);

      run_op(OP_SUB, 32'd5, 32'd5, 0, cyc);
      check_val("sub0_res", result, 32'h0);
      check_val("sub0_flags", {28'b0, zero, cout, overflow, err}, 32'b1100);

      run_op(OP_SUB, 32'd3, 32'd5, 0, cyc);
      check_val("sub_neg_res", result, 32'hFFFF_FFFE);
      check_val("sub_neg_flags", {28'b0, zero, cout, overflow, err}, 32'b0000);

      run_op(OP_SLT, 32'hFFFF_FFFD, 32'd2, 0, cyc);
      check_val("slt_lat", cyc, 32'd65);
      check_val("slt_res", result, 32'h1);
      check_val("slt_flags", {28'b0, zero, cout, overflow, err}, 32'b0000);

      run_op(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0, cyc);
      check_val("slt_ovf_res", result, 32'h0);
      check_val("slt_ovf_zero", {31'b0, zero}, 32'd1);

      run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, cyc);
      check_val("and_res", result, 32'hF000_F000);
      check_val("and_lat", cyc, 32'd33);
      run_op(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, cyc);
      check_val("or_res", result, 32'hFFF0_FFF0);
      check_val("or_flags", {28'b0, zero, cout, overflow, err}, 32'b0000);
      run_op(OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, cyc);
      check_val("nor_res", result, 32'h000F_000F);
      check_val("nor_flags", {28'b0, zero, cout, overflow, err}, 32'b0000);

      run_op(4'b1111, 32'h1234_5678, 32'h1, 0, cyc);
      check_val("ill_lat", cyc, 32'd1);
      check_val("ill_err", {31'b0, err}, 32'd1);
      check_val("ill_res", result, 32'h0);

      run_op(OP_ADD, 32'h1234_5678, 32'h1111_1111, 5, cyc);
      check_val("glitch_lat", cyc, 32'd33);
      check_val("glitch_res", result, 32'h2345_6789);
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check_val("glitch_noqueue", pulses, 32'd0);
      check_val("glitch_hold", result, 32'h2345_6789);

      // Abort an ADD so that the edge processing bit 10 sees rst.
      ALU_control = OP_ADD; src1 = 32'hFFFF_FFFF; src2 = 32'h0000_FFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("abort_ready", {31'b0, ready}, 32'd1);
      check_val("abort_res", result, 32'h0);
      check_val("abort_zero", {31'b0, zero}, 32'd1);
      pulses = 0;
      repeat (40) begin
         if (done) pulses++;
         @(posedge clk); #1;
      end
      check_val("abort_nodone", pulses, 32'd0);

      run_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0, cyc);
      check_val("post_lat", cyc, 32'd33);
      check_val("post_res", result, 32'h0);
      check_val("post_flags", {28'b0, zero, cout, overflow, err}, 32'b1100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that executes one WIDTH-bit MIPS-style ALU operation on a single ALU_1bit instance, processing one bit per clock, LSB first.
- Latches the operands and the opcode, drives Ainvert/Binvert/cin/operation/less per cycle, and chains the carry through a register.
- Assembles result, zero, cout and overflow, then pulses done.
- It is the area-minimal replacement for a rippled WIDTH-slice ALU in the lab datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- src1  input  WIDTH  operand A; sampled on the accepting edge.
- src2  input  WIDTH  operand B; sampled on the accepting edge.
- ALU_control  input  4  opcode; sampled on the accepting edge.
- ready  output  1  high in IDLE.
- done  output  1  single-cycle completion pulse.
- result  output  WIDTH  operation result; holds its value until the next accept.
- zero  output  1  high when result == 0.
- cout  output  1  final carry for ADD/SUB, 0 otherwise.
- overflow  output  1  signed overflow for ADD/SUB, 0 otherwise.
- err  output  1  high with done when the opcode is unsupported.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, result=0, zero=1, cout=0, overflow=0, err=0, bit index=0, carry register=0.
- Opcodes and per-bit ALU_1bit drive (Ainvert, Binvert, cin0, operation):
  - 0000 AND: 0,0,-,00
  - 0001 OR: 0,0,-,01
  - 0010 ADD: 0,0,0,10
  - 0110 SUB: 0,1,1,10
  - 1100 NOR: 1,1,-,00
  - 0111 SLT: two passes, described below.
- States: IDLE, RUN, SLT2, FIN.
- IDLE:
  - start=1 latches src1, src2 and ALU_control, sets idx=0 and carry=cin0, then goes to RUN (or to FIN with err=1 if the opcode is unsupported).
  - start=0 stays in IDLE.
- RUN (one edge per bit):
  - The ALU sees a=A[idx], b=B[idx], cin=carry, less=0.
  - The edge stores result[idx]=sum and carry<=ALU carry, then idx++.
  - On idx==WIDTH-1 the edge also captures the MSB carry-in (for overflow) and carry-out.
  - It then goes to FIN, or for SLT to SLT2 with idx=0.
  - For SLT the RUN pass is a subtract (Binvert=1, cin0=1). Its sum bits go to a shadow register only; result is untouched.
  - set = sum_msb XOR overflow, i.e. a signed-correct compare.
- SLT2 (WIDTH edges):
  - operation=11; less=set at idx 0 and less=0 otherwise; Binvert=1; carry chained as in RUN.
  - result[idx]=sum. Result is {WIDTH-1 zeros, set}.
  - After the last bit, go to FIN.
- FIN (one cycle):
  - done=1. zero, cout and overflow are registered valid in this cycle.
  - For SLT, cout=0 and overflow=0.
  - Next state is IDLE.
- Latency (accept edge = edge 0; done high in the cycle after edge N):
  - Non-SLT ops: N = WIDTH+1.
  - SLT: N = 2*WIDTH+1.
  - Unsupported opcode: N = 1.
- ready=0 from the accept edge until FIN completes. FIN→IDLE lasts one cycle, so back-to-back throughput is one op per WIDTH+2 cycles.
- start while not ready is ignored. It is not queued, and the latched operands and opcode are unaffected by input changes.
- During RUN/SLT2, result contains partially updated bits. Consumers use it only when done=1 or when ready=1 after done.
- rst in any state aborts the operation next edge; all outputs return to reset values and no done is issued.
- Arithmetic is modulo 2^WIDTH. cout = carry-out of the MSB. overflow = carry-in(MSB) XOR carry-out(MSB).

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR);
  - ALU_1bit operation encodings (OPR_AND=00, OPR_OR=01, OPR_ADD=10, OPR_LESS=11);
  - the state enum (IDLE, RUN, SLT2, FIN).
- One sub-module: the existing ALU_1bit, instantiated once. All sequencing, opcode decode and carry/result registers live in alu_serial_ctrl.

Test Plan (WIDTH=32):
- ADD: src1=0x7FFFFFFF, src2=0x00000001 -> result=0x80000000, overflow=1, cout=0, zero=0; done exactly 33 cycles after the accept edge.
- SUB: src1=5, src2=5 -> result=0, zero=1, cout=1, overflow=0. Then SUB 3-5 -> 0xFFFFFFFE, cout=0.
- SLT: src1=0xFFFFFFFD (-3), src2=2 -> result=1, done at cycle 65. SLT 0x7FFFFFFF vs 0x80000000 -> result=0, checking the overflow-corrected set.
- Logic: src1=0xF0F0F0F0, src2=0xFF00FF00 -> AND=0xF000F000, OR=0xFFF0FFF0, NOR=0x000F000F; cout=overflow=0.
- Illegal opcode 1111 -> err=1, done 1 cycle after accept, result=0. Start pulsed in mid-RUN of an ADD -> ignored; ADD result is unchanged.
- rst asserted at bit 10 of an ADD -> next cycle ready=1, result=0, zero=1, done never pulses. A new ADD then completes correctly.
